packet_splitter: RTL and testbench
==================================

// Module: packet_splitter
// PURPOSE
//  Transmit-side counterpart of the flit collector: accepts whole packets (PAYLOAD bits + routing
//  fields) from a core, queues up to QUEUE_DEPTH of them, and emits them as FLIT_COUNT flits, one
//  per cycle, onto a NoC injection port in the exact flit format the collector unpacks.
// PARAMETERS
//  NODE_COUNT       8   nodes in NoC; NODE_W = $clog2(NODE_COUNT)
//  PACKET_ID_WIDTH  5   packet id width (ID_W)
//  PAYLOAD          32  packet payload bits
//  FLIT_PAYLOAD     8   data bits per flit; FLIT_COUNT = ceil(PAYLOAD/FLIT_PAYLOAD), IDX_W = max(1,$clog2(FLIT_COUNT))
//  QUEUE_DEPTH      4   packet queue entries, power of 2, >= 2
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           async active-low reset
//  ce           in   1           clock enable; low = full freeze (no accept, no send, no state change)
//  pkt_valid    in   1           packet offered
//  pkt_ready    out  1           queue can accept; = !full (no same-cycle pop bypass)
//  pkt_data     in   PAYLOAD     packet payload
//  node_start   in   NODE_W      source node
//  node_dest    in   NODE_W      destination node
//  packet_id_in in   ID_W        packet id (ignored when SPLITTER_AUTO_ID_EN)
//  packet_id_out out ID_W        id assigned to packet accepted this cycle (valid when pkt_valid&&pkt_ready&&ce)
//  flit_valid   out  1           flit_out holds a flit
//  flit_ready   in   1           NoC accepts flit
//  flit_out     out  FLIT_WIDTH  {valid_bit, node_dest, data[FLIT_PAYLOAD], packet_id, node_start, byte_index[IDX_W]}, MSB..LSB
//  busy         out  1           queue non-empty or flit in flight
// BEHAVIOUR
//  - Reset (async, immediate): queue emptied, FSM=IDLE, flit_valid=0, flit_out=0, busy=0, pkt_ready=1, id counter=0.
//  - Accept: ce && pkt_valid && pkt_ready -> push {pkt_data,node_start,node_dest,id}. Full -> pkt_ready=0.
//  - FSM IDLE: queue non-empty && ce -> load head, byte_index=0, flit_valid=1 next edge, go SEND.
//  - FSM SEND: transfer = ce && flit_valid && flit_ready. On transfer idx<FLIT_COUNT-1 -> idx+1, next flit.
//    On transfer of last flit: pop head; if queue non-empty (incl. push landing this edge? no: only entries
//    present before edge) load next packet, idx=0, flit_valid stays 1 (no bubble); else flit_valid=0, IDLE.
//  - Stall: flit_valid && !flit_ready -> flit_out held bit-stable; flit_valid never drops without transfer.
//  - Latency: packet pushed at edge N into empty idle block -> flit 0 valid after edge N+1.
//  - Slicing: flit k data = packet[PAYLOAD-1-k*FLIT_PAYLOAD -: FLIT_PAYLOAD] (MSB slice first, index 0);
//    if PAYLOAD%FLIT_PAYLOAD!=0 last flit's low bits zero-padded. valid_bit=1 in every emitted flit.
//  - Simultaneous push and last-flit pop at full: push refused (pkt_ready=0 that cycle); pop proceeds.
//  - Queue pointers wrap modulo QUEUE_DEPTH; count width $clog2(QUEUE_DEPTH)+1.
//  - ce low mid-packet: everything frozen, flit_out/flit_valid held; flit_ready ignored.
//  - Reset mid-packet: remaining flits discarded; collector-side timeout handles partial packet.
// CONFIGURATION
//  SPLITTER_AUTO_ID_EN defined: packet_id_in ignored; id = internal ID_W counter, assigned at accept,
//   increments per accepted packet, wraps 2^ID_W-1 -> 0. packet_id_out = assigned id.
//  Not defined: id = packet_id_in, passed through unchanged; packet_id_out = packet_id_in.
// TESTING (NODE_COUNT=8, ID_W=5, PAYLOAD=32, FLIT_PAYLOAD=8 -> FLIT_WIDTH=22)
//  1 Push 0xDEADBEEF start=2 dest=5 id=3, flit_ready=1 -> 4 consecutive flits data DE,AD,BE,EF,
//    idx 0..3, each flit_out={1,3'd5,data,5'd3,3'd2,idx}; flit 0 one cycle after accept; then busy=0.
//  2 Same push, flit_ready=0 for 5 cycles during flit 1 -> flit_out frozen at AD/idx1, then resumes, no loss/dup.
//  3 Push 5 packets back-to-back, flit_ready=0 -> pkt_ready=0 after 4th; release -> 16 flits contiguous,
//    in order, no bubble at packet boundaries; 5th accepted once a slot frees.
//  4 ce=0 for 3 cycles mid-packet with flit_ready=1 -> no index advance, no accept; continues after.
//  5 rst_n low mid-packet (after idx1) -> flit_valid=0 immediately, busy=0, pkt_ready=1; next packet starts idx0.
//  6 SPLITTER_AUTO_ID_EN: 33 packets -> ids 0..31,0; without macro ids equal packet_id_in.

Source files
------------

// File: rtl/packet_splitter_if.sv
// -----------------------------------------------------------------------------
// packet_splitter_if
//   Bundles the packet-side and flit-side handshakes of packet_splitter.
//   slave  : the splitter's view (accepts packets, drives flits)
//   master : the environment's view (core offering packets, NoC sinking flits)
// Signals
//   pkt_valid/pkt_ready     packet handshake
//   pkt_data                PAYLOAD-bit packet payload
//   node_start/node_dest    routing fields, NODE_W bits each
//   packet_id_in/_out       caller-supplied id / id actually assigned on accept
//   flit_valid/flit_ready   flit handshake
//   flit_out                {valid_bit, node_dest, data, packet_id, node_start, byte_index}
// -----------------------------------------------------------------------------
interface packet_splitter_if #(
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int PAYLOAD         = 32,
    parameter int FLIT_PAYLOAD    = 8
);
    localparam int NODE_W     = $clog2(NODE_COUNT);
    localparam int ID_W       = PACKET_ID_WIDTH;
    localparam int FLIT_COUNT = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD;
    localparam int IDX_W      = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1;
    localparam int FLIT_WIDTH = 1 + NODE_W + FLIT_PAYLOAD + ID_W + NODE_W + IDX_W;

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [PAYLOAD-1:0]    pkt_data;
    logic [NODE_W-1:0]     node_start;
    logic [NODE_W-1:0]     node_dest;
    logic [ID_W-1:0]       packet_id_in;
    logic [ID_W-1:0]       packet_id_out;
    logic                  flit_valid;
    logic                  flit_ready;
    logic [FLIT_WIDTH-1:0] flit_out;

    modport slave (
        input  pkt_valid, pkt_data, node_start, node_dest, packet_id_in, flit_ready,
        output pkt_ready, packet_id_out, flit_valid, flit_out
    );

    modport master (
        output pkt_valid, pkt_data, node_start, node_dest, packet_id_in, flit_ready,
        input  pkt_ready, packet_id_out, flit_valid, flit_out
    );
endinterface

// File: rtl/packet_splitter.sv
// -----------------------------------------------------------------------------
// packet_splitter
//   Queues up to QUEUE_DEPTH whole packets and serialises each into FLIT_COUNT
//   flits (MSB slice first), one per cycle, onto a NoC injection port.
// Ports
//   clk    clock
//   rst_n  async active-low reset
//   ce     clock enable; low freezes all state and handshakes
//   busy   queue non-empty or flit in flight
//   bus    packet_splitter_if.slave (packet in, flit out)
// Configuration
//   SPLITTER_AUTO_ID_EN  defined: ids come from an internal wrapping counter
//                        undefined: ids pass through from packet_id_in
// -----------------------------------------------------------------------------
module packet_splitter #(
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int PAYLOAD         = 32,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    output logic                busy,
    packet_splitter_if.slave    bus
);
    localparam int NODE_W     = $clog2(NODE_COUNT);
    localparam int ID_W       = PACKET_ID_WIDTH;
    localparam int FLIT_COUNT = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD;
    localparam int IDX_W      = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1;
    localparam int FLIT_W     = 1 + NODE_W + FLIT_PAYLOAD + ID_W + NODE_W + IDX_W;
    localparam int PAD_W      = FLIT_COUNT * FLIT_PAYLOAD;
    localparam int PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLIT_COUNT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Packet queue storage. The head entry stays resident until its last flit
    // is sent, so flits are always sliced straight out of the queue.
    logic [PAYLOAD-1:0] pay_mem   [QUEUE_DEPTH];
    logic [NODE_W-1:0]  start_mem [QUEUE_DEPTH];
    logic [NODE_W-1:0]  dest_mem  [QUEUE_DEPTH];
    logic [ID_W-1:0]    id_mem    [QUEUE_DEPTH];

    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              fv_q, fv_d;
    logic [FLIT_W-1:0] fo_q, fo_d;

    logic              full, push, pop, xfer;
    logic [ID_W-1:0]   acc_id;

    assign full = (cnt_q == CNT_W'(QUEUE_DEPTH));
    assign push = ce && bus.pkt_valid && !full;
    assign xfer = ce && fv_q && bus.flit_ready;

`ifdef SPLITTER_AUTO_ID_EN
    logic [ID_W-1:0] id_q;
    logic            unused_id_in;

    assign unused_id_in = ^bus.packet_id_in;
    assign acc_id       = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    id_q <= '0;
        else if (push) id_q <= id_q + 1'b1;
    end
`else
    assign acc_id = bus.packet_id_in;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            pay_mem[wr_q]   <= bus.pkt_data;
            start_mem[wr_q] <= bus.node_start;
            dest_mem[wr_q]  <= bus.node_dest;
            id_mem[wr_q]    <= acc_id;
        end
    end

    // Build flit k of queue entry p; a short final slice is zero-padded low.
    function automatic logic [FLIT_W-1:0] make_flit(input logic [PTR_W-1:0] p,
                                                    input logic [IDX_W-1:0] k);
        logic [PAD_W-1:0]        padded;
        logic [FLIT_PAYLOAD-1:0] slice;
        padded                   = '0;
        padded[PAD_W-1 -: PAYLOAD] = pay_mem[p];
        slice = FLIT_PAYLOAD'(padded >> ((FLIT_COUNT - 1 - int'(k)) * FLIT_PAYLOAD));
        return {1'b1, dest_mem[p], slice, id_mem[p], start_mem[p], k};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fv_d    = fv_q;
        fo_d    = fo_q;
        rd_d    = rd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ce && cnt_q != '0) begin
                    idx_d   = '0;
                    fv_d    = 1'b1;
                    fo_d    = make_flit(rd_q, '0);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                        fo_d  = make_flit(rd_q, idx_q + 1'b1);
                    end else begin
                        pop  = 1'b1;
                        rd_d = rd_q + 1'b1;
                        // Only entries already queued before this edge can chain
                        // without a bubble; a push landing now waits for IDLE.
                        if (cnt_q > CNT_W'(1)) begin
                            idx_d = '0;
                            fo_d  = make_flit(rd_q + 1'b1, '0);
                        end else begin
                            idx_d   = '0;
                            fv_d    = 1'b0;
                            fo_d    = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            fv_q    <= 1'b0;
            fo_q    <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            fv_q    <= fv_d;
            fo_q    <= fo_d;
        end
    end

    assign bus.pkt_ready     = !full;
    assign bus.packet_id_out = acc_id;
    assign bus.flit_valid    = fv_q;
    assign bus.flit_out      = fo_q;
    assign busy              = (cnt_q != '0) || fv_q;
endmodule

// File: tb/tb_packet_splitter.sv
module tb_packet_splitter;
    localparam int NC = 8, IDW = 5, PL = 32, FP = 8, QD = 4, FW = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    packet_splitter_if #(.NODE_COUNT(NC), .PACKET_ID_WIDTH(IDW), .PAYLOAD(PL),
                         .FLIT_PAYLOAD(FP)) bif ();

    packet_splitter #(.NODE_COUNT(NC), .PACKET_ID_WIDTH(IDW), .PAYLOAD(PL),
                      .FLIT_PAYLOAD(FP), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .busy(busy), .bus(bif));

    int total = 0;
    int bad = 0;
    int xfers = 0;
    logic [FW-1:0] sb[$];
    logic [IDW-1:0] id_model = '0;
    logic [IDW-1:0] eid;
    logic prev_stall = 1'b0;
    logic [FW-1:0] prev_flit;
    logic done6;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [31:0] d, input logic [2:0] s,
                                         input logic [2:0] dst, input logic [4:0] id,
                                         input int k);
        logic [7:0] b;
        b = 8'(d >> (8 * (3 - k)));
        return {1'b1, dst, b, id, s, 2'(k)};
    endfunction

    // Scoreboard monitor: inputs change only at posedge+1, so the negedge view
    // is exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(bif.flit_valid), 64'd1);
                chk("stall_hold", 64'(bif.flit_out), 64'(prev_flit));
            end
            prev_stall = bif.flit_valid && !(ce && bif.flit_ready);
            prev_flit  = bif.flit_out;
            if (ce) begin
                if (bif.flit_valid && bif.flit_ready) begin
                    xfers++;
                    if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
                    else chk("flit", 64'(bif.flit_out), 64'(sb.pop_front()));
                end
                if (bif.pkt_valid && bif.pkt_ready) begin
`ifdef SPLITTER_AUTO_ID_EN
                    eid = id_model;
                    id_model = id_model + 1'b1;
`else
                    eid = bif.packet_id_in;
`endif
                    chk("pkt_id_out", 64'(bif.packet_id_out), 64'(eid));
                    for (int k = 0; k < 4; k++)
                        sb.push_back(mk(bif.pkt_data, bif.node_start, bif.node_dest, eid, k));
                end
            end
        end
    end

    task automatic push_pkt(input logic [31:0] d, input logic [2:0] s, input logic [2:0] dst,
                            input logic [4:0] id);
        bif.pkt_data = d;
        bif.node_start = s;
        bif.node_dest = dst;
        bif.packet_id_in = id;
        bif.pkt_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bif.pkt_ready && ce) begin
                @(posedge clk);
                #1;
                bif.pkt_valid = 1'b0;
                return;
            end
        end
        bif.pkt_valid = 1'b0;
        chk("push_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (!busy && sb.size() == 0) break;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [4:0] pred_id(input logic [4:0] in_id);
`ifdef SPLITTER_AUTO_ID_EN
        return id_model;
`else
        return in_id;
`endif
    endfunction

    initial begin
        logic [4:0] pid;
        logic [FW-1:0] lit;
        int x0;
        bif.pkt_valid = 1'b0;
        bif.pkt_data = '0;
        bif.node_start = '0;
        bif.node_dest = '0;
        bif.packet_id_in = '0;
        bif.flit_ready = 1'b1;
        #12;
        chk("rst_fv", 64'(bif.flit_valid), 64'd0);
        chk("rst_fo", 64'(bif.flit_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(bif.pkt_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: basic packet and latency
        pid = pred_id(5'd3);
        push_pkt(32'hDEADBEEF, 3'd2, 3'd5, 5'd3);
        chk("lat_n", 64'(bif.flit_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n1", 64'(bif.flit_valid), 64'd1);
        chk("t1_f0", 64'(bif.flit_out), 64'(mk(32'hDEADBEEF, 3'd2, 3'd5, pid, 0)));
`ifndef SPLITTER_AUTO_ID_EN
        lit = {1'b1, 3'd5, 8'hDE, 5'd3, 3'd2, 2'd0};
        chk("t1_lit", 64'(bif.flit_out), 64'(lit));
`endif
        drain();

        // 2: stall during flit 1
        pid = pred_id(5'd3);
        push_pkt(32'hDEADBEEF, 3'd2, 3'd5, 5'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bif.flit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t2_hold", 64'(bif.flit_out), 64'(mk(32'hDEADBEEF, 3'd2, 3'd5, pid, 1)));
        end
        bif.flit_ready = 1'b1;
        drain();

        // 3: fill the queue, then release
        bif.flit_ready = 1'b0;
        for (int p = 0; p < 4; p++)
            push_pkt(32'h11223344 * (p + 1), 3'(p), 3'(7 - p), 5'(10 + p));
        chk("t3_full", 64'(bif.pkt_ready), 64'd0);
        fork
            push_pkt(32'hCAFEF00D, 3'd6, 3'd1, 5'd20);
            begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                chk("t3_full_hold", 64'(bif.pkt_ready), 64'd0);
                bif.flit_ready = 1'b1;
                x0 = xfers;
                repeat (16) @(posedge clk);
                #1;
                chk("t3_contig", 64'(xfers - x0), 64'd16);
            end
        join
        drain();

        // 4: clock-enable freeze mid-packet
        pid = pred_id(5'd7);
        push_pkt(32'hA5A55A5A, 3'd1, 3'd4, 5'd7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        bif.pkt_data = 32'h0BADF00D;
        bif.pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t4_freeze", 64'(bif.flit_out), 64'(mk(32'hA5A55A5A, 3'd1, 3'd4, pid, 1)));
        end
        bif.pkt_valid = 1'b0;
        ce = 1'b1;
        drain();

        // 5: reset mid-packet
        push_pkt(32'h01234567, 3'd3, 3'd6, 5'd9);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_fv", 64'(bif.flit_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_rdy", 64'(bif.pkt_ready), 64'd1);
        sb.delete();
        id_model = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pid = pred_id(5'd12);
        push_pkt(32'h89ABCDEF, 3'd0, 3'd7, 5'd12);
        @(posedge clk);
        #1;
        chk("t5_restart", 64'(bif.flit_out), 64'(mk(32'h89ABCDEF, 3'd0, 3'd7, pid, 0)));
        drain();

        // 6: 33 packets with random backpressure
        done6 = 1'b0;
        fork
            begin
                for (int p = 0; p < 33; p++)
                    push_pkt($urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                             5'($urandom_range(0, 31)));
                done6 = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !done6; c++) begin
                    @(posedge clk);
                    #1;
                    bif.flit_ready = 1'($urandom_range(0, 1));
                end
                bif.flit_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
